// File: rtl/branch_redirect_ctrl.sv
// EX-stage control-flow redirect sequencer: computes taken targets, hands them
// to fetch over valid/ready, flushes IF/ID afterwards and tracks perf counters.
`ifndef DataBusBits
`define DataBusBits 31:0
`endif

module branch_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_BITS     = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ex_valid,
  input  logic [`DataBusBits] ex_instr,
  input  logic [`DataBusBits] ex_pc,
  input  logic [`DataBusBits] ex_imm,
  input  logic [`DataBusBits] ex_rs1,
  input  logic                takebranch,
  input  logic                redirect_ready,
  output logic                redirect_valid,
  output logic [`DataBusBits] redirect_pc,
  output logic                flush_ifid,
  output logic                stall_ex,
  output logic                misalign_exc,
  output logic [`DataBusBits] misalign_pc,
  output logic [CNT_BITS-1:0] cnt_resolved,
  output logic [CNT_BITS-1:0] cnt_taken
);

  typedef enum logic [1:0] {IDLE, REDIR, FLUSH} state_t;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam int unsigned FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t               state, state_n;
  logic [FCW-1:0]       fcnt, fcnt_n;
  logic                 rv_n, fl_n, st_n, me_n;
  logic [`DataBusBits]  rpc_n, mpc_n, target;
  logic [CNT_BITS-1:0]  cr_n, ct_n;
  logic [6:0]           opcode;
  logic                 is_cf, is_jalr;
  logic                 unused_instr;

  assign opcode       = ex_instr[6:0];
  assign is_jalr      = (opcode == OP_JALR);
  assign is_cf        = (opcode == OP_BRANCH) || (opcode == OP_JAL) || is_jalr;
  assign unused_instr = ^ex_instr[31:7];

  always_comb begin
    target = ex_pc + ex_imm;
    if (is_jalr) begin
      target    = ex_rs1 + ex_imm;
      target[0] = 1'b0;
    end
  end

  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    rv_n    = redirect_valid;
    rpc_n   = redirect_pc;
    fl_n    = flush_ifid;
    st_n    = stall_ex;
    me_n    = 1'b0;
    mpc_n   = misalign_pc;
    cr_n    = cnt_resolved;
    ct_n    = cnt_taken;
    case (state)
      IDLE: begin
        if (ex_valid && is_cf) begin
          cr_n = cnt_resolved + CNT_BITS'(1);
          if (takebranch) begin
            if (!target[1]) begin
              rpc_n   = target;
              rv_n    = 1'b1;
              st_n    = 1'b1;
              fl_n    = 1'b1;
              ct_n    = cnt_taken + CNT_BITS'(1);
              state_n = REDIR;
            end else begin
              me_n  = 1'b1;
              mpc_n = target;
            end
          end
        end
      end
      REDIR: begin
        if (redirect_ready) begin
          rv_n = 1'b0;
          st_n = 1'b0;
          if (FLUSH_CYCLES > 1) begin
            fcnt_n  = FCW'(FLUSH_CYCLES - 1);
            state_n = FLUSH;
          end else begin
            fl_n    = 1'b0;
            state_n = IDLE;
          end
        end
      end
      FLUSH: begin
        // flush drops on the edge where the counter reaches zero
        fcnt_n = fcnt - FCW'(1);
        if (fcnt <= FCW'(1)) begin
          fcnt_n  = '0;
          fl_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      fcnt           <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_ifid     <= 1'b0;
      stall_ex       <= 1'b0;
      misalign_exc   <= 1'b0;
      misalign_pc    <= '0;
      cnt_resolved   <= '0;
      cnt_taken      <= '0;
    end else begin
      state          <= state_n;
      fcnt           <= fcnt_n;
      redirect_valid <= rv_n;
      redirect_pc    <= rpc_n;
      flush_ifid     <= fl_n;
      stall_ex       <= st_n;
      misalign_exc   <= me_n;
      misalign_pc    <= mpc_n;
      cnt_resolved   <= cr_n;
      cnt_taken      <= ct_n;
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: per-cycle comparison against a
// behavioural model plus literal spot checks at hand-computed points.
module tb_branch_redirect_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam logic [31:0] I_BEQ  = 32'h0000_0063;
  localparam logic [31:0] I_BNE  = 32'h0000_1063;
  localparam logic [31:0] I_JAL  = 32'h0000_006F;
  localparam logic [31:0] I_JALR = 32'h0000_0067;
  localparam logic [31:0] I_ADD  = 32'h0000_0033;

  logic        clk = 1'b0;
  logic        reset, ex_valid, takebranch, redirect_ready;
  logic [31:0] ex_instr, ex_pc, ex_imm, ex_rs1;
  logic        redirect_valid, flush_ifid, stall_ex, misalign_exc;
  logic [31:0] redirect_pc, misalign_pc, cnt_resolved, cnt_taken;

  int n_tests = 0;
  int n_fail  = 0;

  branch_redirect_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_BITS(32)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_instr(ex_instr),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .takebranch(takebranch),
    .redirect_ready(redirect_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush_ifid(flush_ifid), .stall_ex(stall_ex),
    .misalign_exc(misalign_exc), .misalign_pc(misalign_pc),
    .cnt_resolved(cnt_resolved), .cnt_taken(cnt_taken)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a pending redirect blocks everything; after acceptance the flush
  // persists for FLUSH_CYCLES-1 more cycles; only then is EX considered again.
  logic        e_rv, e_fl, e_st, e_me;
  logic [31:0] e_pc, e_mpc, e_cr, e_ct, tgt;
  int          flush_left;
  bit          started = 0;

  always @(posedge clk) begin
    started = 1;
    if (reset) begin
      e_rv = 0; e_pc = 0; e_me = 0; e_mpc = 0; e_cr = 0; e_ct = 0;
      flush_left = 0;
    end else begin
      e_me = 0;
      if (e_rv) begin
        if (redirect_ready) begin
          e_rv = 0;
          flush_left = FLUSH_CYCLES - 1;
        end
      end else if (flush_left > 0) begin
        flush_left--;
      end else if (ex_valid && (ex_instr[6:0] == 7'h63 || ex_instr[6:0] == 7'h6F ||
                                ex_instr[6:0] == 7'h67)) begin
        e_cr++;
        if (ex_instr[6:0] == 7'h67) tgt = (ex_rs1 + ex_imm) & 32'hFFFF_FFFE;
        else                        tgt = ex_pc + ex_imm;
        if (takebranch) begin
          if (tgt % 4 == 0 || tgt % 4 == 1) begin
            e_rv = 1; e_pc = tgt; e_ct++;
          end else begin
            e_me = 1; e_mpc = tgt;
          end
        end
      end
    end
    e_st = e_rv;
    e_fl = e_rv || (flush_left > 0);
  end

  always @(negedge clk) begin
    if (started) begin
      check("redirect_valid", {31'b0, redirect_valid}, {31'b0, e_rv});
      check("redirect_pc",    redirect_pc,  e_pc);
      check("flush_ifid",     {31'b0, flush_ifid}, {31'b0, e_fl});
      check("stall_ex",       {31'b0, stall_ex},   {31'b0, e_st});
      check("misalign_exc",   {31'b0, misalign_exc}, {31'b0, e_me});
      check("misalign_pc",    misalign_pc,  e_mpc);
      check("cnt_resolved",   cnt_resolved, e_cr);
      check("cnt_taken",      cnt_taken,    e_ct);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] rs1, input logic tk);
    ex_valid = v; ex_instr = ins; ex_pc = pc; ex_imm = imm; ex_rs1 = rs1; takebranch = tk;
  endtask

  initial begin
    reset = 1; redirect_ready = 0;
    drive(1, I_BEQ, 32'h100, 32'h20, 0, 1);
    step(); step();
    check("reset_rv",  {31'b0, redirect_valid}, 32'h0);
    check("reset_cnt", cnt_resolved, 32'h0);
    reset = 0;
    drive(0, I_ADD, 0, 0, 0, 0);
    step();

    // BEQ taken, accepted on first REDIR cycle
    drive(1, I_BEQ, 32'h100, 32'h20, 0, 1);
    step();
    drive(0, I_ADD, 0, 0, 0, 0);
    redirect_ready = 1;
    check("beq_pc", redirect_pc, 32'h120);
    check("beq_rv", {31'b0, redirect_valid}, 32'h1);
    step();
    check("beq_rv_drop", {31'b0, redirect_valid}, 32'h0);
    check("beq_flush2",  {31'b0, flush_ifid}, 32'h1);
    step();
    check("beq_flush_end", {31'b0, flush_ifid}, 32'h0);
    check("beq_taken", cnt_taken, 32'h1);
    check("beq_resolved", cnt_resolved, 32'h1);
    redirect_ready = 0;

    // JALR with 4 cycles of backpressure; EX kept busy to prove it is ignored
    drive(1, I_JALR, 32'h500, 32'h3, 32'h2001, 1);
    step();
    for (int i = 0; i < 4; i++) begin
      check("jalr_hold_pc", redirect_pc, 32'h2004);
      check("jalr_stall",   {31'b0, stall_ex}, 32'h1);
      step();
    end
    check("jalr_pc5", redirect_pc, 32'h2004);
    redirect_ready = 1;
    step();
    redirect_ready = 0;
    check("jalr_flush", {31'b0, flush_ifid}, 32'h1);
    check("jalr_nostall", {31'b0, stall_ex}, 32'h0);
    drive(0, I_ADD, 0, 0, 0, 0);
    step();
    check("jalr_taken", cnt_taken, 32'h2);
    check("jalr_resolved", cnt_resolved, 32'h2);

    // not-taken BNE, ADD with and without takebranch
    drive(1, I_BNE, 32'h40, 32'h8, 0, 0); step();
    drive(1, I_ADD, 32'h44, 32'h8, 0, 0); step();
    drive(1, I_ADD, 32'h48, 32'h8, 0, 1); step();
    check("nt_resolved", cnt_resolved, 32'h3);
    check("nt_rv", {31'b0, redirect_valid}, 32'h0);

    // misaligned JAL
    drive(1, I_JAL, 32'h10, 32'h6, 0, 1); step();
    check("mis_exc", {31'b0, misalign_exc}, 32'h1);
    check("mis_pc",  misalign_pc, 32'h16);
    drive(0, I_ADD, 0, 0, 0, 0); step();
    check("mis_pulse", {31'b0, misalign_exc}, 32'h0);
    check("mis_taken", cnt_taken, 32'h2);

    // wrap-around target, then reset mid-REDIR
    drive(1, I_BEQ, 32'hFFFF_FFF0, 32'h20, 0, 1); step();
    check("wrap_pc", redirect_pc, 32'h10);
    drive(0, I_ADD, 0, 0, 0, 0);
    reset = 1; step();
    check("rst_mid_rv", {31'b0, redirect_valid}, 32'h0);
    check("rst_mid_fl", {31'b0, flush_ifid}, 32'h0);
    reset = 0;
    redirect_ready = 1; step();   // ready in IDLE is ignored
    drive(1, I_BEQ, 32'h0, 32'h8, 0, 1); step();
    drive(0, I_ADD, 0, 0, 0, 0);
    check("post_rst_taken", cnt_taken, 32'h1);
    step(); step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences control-flow changes for the core.
- Consumes the EX-stage branch decision (takebranch from the branch unit) and computes the target PC.
- Issues a redirect to fetch with a valid/ready handshake, then flushes the wrong-path IF/ID instructions for a programmable number of cycles and stalls EX until the redirect is accepted.
- Fetch predicts not-taken, so only taken branches, JAL and JALR generate redirects. Keeps taken/resolved performance counters.

Parameters:
- FLUSH_CYCLES, 2, cycles flush_ifid stays high after the redirect is accepted (≥1)
- CNT_BITS, 32, width of the performance counters

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- ex_valid  input  1  a valid instruction occupies EX this cycle
- ex_instr  input  `DataBusBits  instruction in EX (opcode [6:0], funct3 [14:12])
- ex_pc  input  `DataBusBits  PC of the EX instruction
- ex_imm  input  `DataBusBits  sign-extended B/J/I immediate from decode
- ex_rs1  input  `DataBusBits  rs1 operand (JALR base)
- takebranch  input  1  branch-unit decision; 1 for JAL/JALR
- redirect_ready  input  1  fetch accepts the redirect this cycle
- redirect_valid  output  1  redirect request to fetch
- redirect_pc  output  `DataBusBits  new fetch PC, held stable while redirect_valid
- flush_ifid  output  1  squash the IF and ID stage contents
- stall_ex  output  1  hold EX and earlier stages
- misalign_exc  output  1  one-cycle pulse: taken target not 4-byte aligned
- misalign_pc  output  `DataBusBits  faulting target, captured with misalign_exc
- cnt_resolved  output  CNT_BITS  branches/jumps resolved
- cnt_taken  output  CNT_BITS  redirects issued

Behaviour:
- Reset (synchronous, active-high) forces state IDLE and clears every output to 0, including both counters and the flush counter. Reset asserted mid-operation aborts any pending redirect or flush the next edge.
- Control-flow instruction (cf): opcode is BRANCH (1100011), JAL or JALR.
- Target computation, 32-bit, wrap-around, no overflow detection:
  - Branch/JAL: ex_pc + ex_imm.
  - JALR: (ex_rs1 + ex_imm) with bit0 forced to 0.
- States:
  - IDLE:
    - ex_valid & cf: cnt_resolved increments.
    - If takebranch and target[1]==0: latch redirect_pc = target, assert redirect_valid, stall_ex and flush_ifid next cycle, cnt_taken increments, go to REDIR.
    - If takebranch and target[1]==1: pulse misalign_exc for 1 cycle with misalign_pc = target, no redirect, stay in IDLE.
    - Not taken, or not cf: no action.
    - Decision latency is 1 cycle: outputs register on the edge after the EX cycle.
  - REDIR:
    - redirect_valid, stall_ex and flush_ifid are held high. redirect_pc must not change.
    - EX inputs are ignored and not counted, since EX is stalled.
    - redirect_ready=1: drop redirect_valid and stall_ex next cycle. If FLUSH_CYCLES>1, load flush counter with FLUSH_CYCLES-1 and go to FLUSH; otherwise go to IDLE with flush_ifid low.
  - FLUSH:
    - flush_ifid high, stall_ex low. Counter decrements each cycle; at 0 drop flush_ifid and go to IDLE.
    - ex_valid during FLUSH is a squashed bubble and is ignored.
- redirect_ready while in IDLE or FLUSH is ignored.
- Counters wrap modulo 2^CNT_BITS.
- Outputs are registered; there are no combinational input→output paths.

Test Plan:
- Reset: assert reset 2 cycles with ex_valid=1, takebranch=1 → all outputs 0; state IDLE after release.
- BEQ taken: ex_pc=0x100, ex_imm=0x20, takebranch=1, redirect_ready=1 one cycle later → redirect_pc=0x120, redirect_valid high exactly 1 cycle, flush_ifid high 2 cycles total, cnt_taken=1, cnt_resolved=1.
- JALR with backpressure: ex_rs1=0x2001, ex_imm=0x3, redirect_ready=0 for 4 cycles then 1 → redirect_pc=0x2004 stable for 5 cycles, stall_ex high for 5 cycles, then FLUSH for 1 cycle.
- Not-taken BNE, plus ADD (0110011) with takebranch=0 → no redirect; cnt_resolved increments for the BNE only.
- Misaligned JAL: ex_pc=0x10, ex_imm=0x6 → misalign_exc 1-cycle pulse, misalign_pc=0x16, redirect_valid stays 0, cnt_taken unchanged.
- Reset mid-REDIR, plus wrap: reset during REDIR → redirect_valid=0 next edge. Separately, ex_pc=0xFFFFFFF0, ex_imm=0x20 → redirect_pc=0x00000010.
